// File: rtl/div_unit_if.sv
// Request/response bundle between the execute stage and the iterative divider.
// The requester drives start/op/operands/flush and watches busy/done/out.
interface div_unit_if #(
    parameter int XLEN = 32
);
    logic            div_start;
    logic [1:0]      div_op;
    logic [XLEN-1:0] div_in1;
    logic [XLEN-1:0] div_in2;
    logic            div_flush;
    logic            div_busy;
    logic            div_done;
    logic [XLEN-1:0] div_out;

    modport master (
        output div_start, div_op, div_in1, div_in2, div_flush,
        input  div_busy, div_done, div_out
    );

    modport slave (
        input  div_start, div_op, div_in1, div_in2, div_flush,
        output div_busy, div_done, div_out
    );
endinterface

// File: rtl/div_unit.sv
// RV32M DIV/DIVU/REM/REMU radix-2 restoring divider; XLEN+2 cycles start-to-done, 2 for special cases.
// No backpressure: requester stalls on div_busy, div_start ignored unless idle; div_flush aborts silently.
module div_unit #(
    parameter int XLEN = 32
) (
    input  logic      clk,
    input  logic      rst_n,
    div_unit_if.slave bus
);
    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    typedef struct packed {
        logic [1:0] op;
        logic       quo_neg;
        logic       rem_neg;
    } ctx_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic [XLEN-1:0] out_q, out_d;
    ctx_t            ctx_q, ctx_d;

    logic            sgn, neg1, neg2;
    logic [XLEN-1:0] a_abs, b_abs;
    logic [XLEN:0]   trial;
    logic            ge;
    logic [XLEN-1:0] rem_nx, quo_nx, q_fix, r_fix;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        out_d   = out_q;
        ctx_d   = ctx_q;

        sgn   = ~bus.div_op[0];
        neg1  = sgn & bus.div_in1[XLEN-1];
        neg2  = sgn & bus.div_in2[XLEN-1];
        a_abs = neg1 ? -bus.div_in1 : bus.div_in1;
        b_abs = neg2 ? -bus.div_in2 : bus.div_in2;

        // Trial subtraction is XLEN+1 bits wide so a set MSB of rem is never lost.
        trial  = {rem_q, quo_q[XLEN-1]};
        ge     = trial >= {1'b0, dvs_q};
        rem_nx = ge ? (trial[XLEN-1:0] - dvs_q) : trial[XLEN-1:0];
        quo_nx = {quo_q[XLEN-2:0], ge};
        q_fix  = ctx_q.quo_neg ? -quo_nx : quo_nx;
        r_fix  = ctx_q.rem_neg ? -rem_nx : rem_nx;

        unique case (state_q)
            IDLE: begin
                if (bus.div_start && !bus.div_flush) begin
                    ctx_d.op      = bus.div_op;
                    ctx_d.quo_neg = neg1 ^ neg2;
                    ctx_d.rem_neg = neg1;
                    if (bus.div_in2 == '0) begin
                        out_d   = bus.div_op[1] ? bus.div_in1 : '1;
                        state_d = DONE;
                    end else if (sgn && bus.div_in1 == INT_MIN && bus.div_in2 == '1) begin
                        out_d   = bus.div_op[1] ? '0 : INT_MIN;
                        state_d = DONE;
                    end else begin
                        rem_d   = '0;
                        quo_d   = a_abs;
                        dvs_d   = b_abs;
                        cnt_d   = '0;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (bus.div_flush) begin
                    state_d = IDLE;
                end else begin
                    rem_d = rem_nx;
                    quo_d = quo_nx;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        out_d   = ctx_q.op[1] ? r_fix : q_fix;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            out_q   <= '0;
            ctx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            out_q   <= out_d;
            ctx_q   <= ctx_d;
        end
    end

    assign bus.div_busy = (state_q != IDLE);
    assign bus.div_done = (state_q == DONE) && !bus.div_flush;
    assign bus.div_out  = out_q;
endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;
    localparam int XLEN = 32;
    localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    div_unit_if #(.XLEN(XLEN)) bus ();
    div_unit #(.XLEN(XLEN)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        bit          fast;
    } vec_t;

    vec_t vecs[16];
    int n_cmp = 0;
    int n_bad = 0;
    int busy_gaps = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_i(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference from RISC-V rules: SV signed / and % truncate toward zero like RV32M.
    function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic is_rem;
        logic [31:0] r;
        is_rem = op[1];
        if (b == 0) return is_rem ? a : 32'hFFFF_FFFF;
        if (!op[0]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return is_rem ? 32'h0 : 32'h8000_0000;
            if (is_rem) r = $signed(a) % $signed(b);
            else        r = $signed(a) / $signed(b);
            return r;
        end
        return is_rem ? (a % b) : (a / b);
    endfunction

    function automatic bit is_fast(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        return (b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    task automatic watch_no_done(input string name, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            if (bus.div_done) seen++;
            @(posedge clk); #1;
        end
        chk_i(name, seen, 0);
    endtask

    // Starts one op and returns at the done cycle; poke>0 re-pulses start mid-op with other operands.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int poke, output logic [31:0] res, output int lat);
        int edges;
        bus.div_start = 1'b1;
        bus.div_op    = op;
        bus.div_in1   = a;
        bus.div_in2   = b;
        @(posedge clk); #1;
        bus.div_start = 1'b0;
        edges = 1;
        while (!bus.div_done && edges < 100) begin
            if (poke != 0 && edges == poke) begin
                bus.div_start = 1'b1;
                bus.div_op    = ~op;
                bus.div_in1   = a ^ 32'h5;
                bus.div_in2   = b + 32'h1;
            end else begin
                bus.div_start = 1'b0;
            end
            if (!bus.div_busy) busy_gaps++;
            @(posedge clk); #1;
            edges++;
        end
        bus.div_start = 1'b0;
        res = bus.div_out;
        lat = bus.div_done ? edges : -1;
    endtask

    logic [31:0] res;
    int          lat;

    initial begin
        vecs[0]  = '{OP_DIVU, 32'd100,        32'd7,          32'd14,         1'b0};
        vecs[1]  = '{OP_REMU, 32'd100,        32'd7,          32'd2,          1'b0};
        vecs[2]  = '{OP_DIV,  32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  1'b0};
        vecs[3]  = '{OP_REM,  32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFFE,  1'b0};
        vecs[4]  = '{OP_REM,  32'd100,        32'hFFFF_FFF9,  32'd2,          1'b0};
        vecs[5]  = '{OP_DIV,  32'd123,        32'd0,          32'hFFFF_FFFF,  1'b1};
        vecs[6]  = '{OP_REMU, 32'd123,        32'd0,          32'd123,        1'b1};
        vecs[7]  = '{OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b1};
        vecs[8]  = '{OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'h0,          1'b1};
        vecs[9]  = '{OP_DIVU, 32'hFFFF_FFFF,  32'd3,          32'h5555_5555,  1'b0};
        vecs[10] = '{OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0,          1'b0};
        vecs[11] = '{OP_DIV,  32'h8000_0000,  32'd1,          32'h8000_0000,  1'b0};
        vecs[12] = '{OP_REM,  32'h8000_0000,  32'd2,          32'h0,          1'b0};
        vecs[13] = '{OP_DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  1'b0};
        vecs[14] = '{OP_REMU, 32'd5,          32'd10,         32'd5,          1'b0};
        vecs[15] = '{OP_DIVU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          1'b0};

        bus.div_start = 1'b0;
        bus.div_op    = 2'b00;
        bus.div_in1   = '0;
        bus.div_in2   = '0;
        bus.div_flush = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", {31'b0, bus.div_busy}, 32'd0);
        chk("reset_done", {31'b0, bus.div_done}, 32'd0);
        chk("reset_out", bus.div_out, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 16; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, res, lat);
            chk($sformatf("vec%0d_out", i), res, vecs[i].exp);
            chk_i($sformatf("vec%0d_lat", i), lat, vecs[i].fast ? 1 : 33);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_idle", i), {30'b0, bus.div_busy, bus.div_done}, 32'd0);
        end

        // Flush mid-CALC: no pulse, previous result kept, then a fresh op works.
        run_op(OP_DIVU, 32'd100, 32'd7, 0, res, lat);
        @(posedge clk); #1;
        bus.div_start = 1'b1; bus.div_op = OP_DIVU; bus.div_in1 = 32'hFFFF_FFFF; bus.div_in2 = 32'd3;
        @(posedge clk); #1;
        bus.div_start = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        bus.div_flush = 1'b1;
        @(posedge clk); #1;
        bus.div_flush = 1'b0;
        chk("flush_busy", {31'b0, bus.div_busy}, 32'd0);
        chk("flush_out_kept", bus.div_out, 32'd14);
        watch_no_done("flush_no_done", 40);
        run_op(OP_DIVU, 32'hFFFF_FFFF, 32'd3, 0, res, lat);
        chk("after_flush_out", res, 32'h5555_5555);
        @(posedge clk); #1;

        // Flush during DONE suppresses the pulse in that very cycle.
        run_op(OP_DIV, 32'd123, 32'd0, 0, res, lat);
        bus.div_flush = 1'b1;
        #1;
        chk("flush_done_forced0", {31'b0, bus.div_done}, 32'd0);
        @(posedge clk); #1;
        bus.div_flush = 1'b0;
        chk("flush_done_busy", {31'b0, bus.div_busy}, 32'd0);

        // Flush in IDLE blocks a simultaneous start.
        bus.div_start = 1'b1; bus.div_flush = 1'b1;
        bus.div_op = OP_DIVU; bus.div_in1 = 32'd9; bus.div_in2 = 32'd3;
        @(posedge clk); #1;
        bus.div_start = 1'b0; bus.div_flush = 1'b0;
        chk("flush_idle_start", {31'b0, bus.div_busy}, 32'd0);

        // Start in the DONE cycle is ignored.
        run_op(OP_REMU, 32'd123, 32'd0, 0, res, lat);
        bus.div_start = 1'b1; bus.div_op = OP_DIVU; bus.div_in1 = 32'd100; bus.div_in2 = 32'd7;
        @(posedge clk); #1;
        bus.div_start = 1'b0;
        chk("start_in_done_busy", {31'b0, bus.div_busy}, 32'd0);
        chk("start_in_done_out", bus.div_out, 32'd123);

        // Start re-pulsed during CALC is ignored.
        run_op(OP_DIVU, 32'd100, 32'd7, 5, res, lat);
        chk("poke_calc_out", res, 32'd14);
        chk_i("poke_calc_lat", lat, 33);
        @(posedge clk); #1;

        // Reset mid-CALC clears outputs with no pulse.
        bus.div_start = 1'b1; bus.div_op = OP_DIVU; bus.div_in1 = 32'hFFFF_FFFF; bus.div_in2 = 32'd3;
        @(posedge clk); #1;
        bus.div_start = 1'b0;
        repeat (8) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_busy", {31'b0, bus.div_busy}, 32'd0);
        chk("rst_mid_done", {31'b0, bus.div_done}, 32'd0);
        chk("rst_mid_out", bus.div_out, 32'd0);
        rst_n = 1'b1;
        watch_no_done("rst_mid_no_done", 40);

        for (int i = 0; i < 150; i++) begin
            logic [1:0]  op;
            logic [31:0] a, b;
            int          sel;
            op  = 2'($urandom_range(0, 3));
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) b = 32'd0;
            else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else if (sel == 2) b = 32'($urandom_range(1, 15));
            else if (sel == 3) a = 32'($urandom_range(0, 255));
            else if (sel == 4) b = -32'($urandom_range(1, 15));
            run_op(op, a, b, 0, res, lat);
            chk($sformatf("rnd%0d_out op=%0d a=%h b=%h", i, op, a, b), res, ref_div(op, a, b));
            chk_i($sformatf("rnd%0d_lat", i), lat, is_fast(op, a, b) ? 1 : 33);
            @(posedge clk); #1;
        end

        chk_i("busy_gaps", busy_gaps, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative multi-cycle divider/remainder unit for the RV32M DIV, DIVU, REM and REMU instructions.
- Complements the combinational ALU multiply path.
- Sits beside the ALU in the execute stage. The pipeline stalls on div_busy and captures div_out on div_done.
- Uses a radix-2 restoring algorithm, one quotient bit per cycle, with single-cycle fast paths for RISC-V special cases.

Parameters:
XLEN, 32, operand/result width; the iteration count equals XLEN.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  reset, synchronous, active-low
div_start  input  1  request strobe; accepted only in IDLE
div_op  input  2  00=DIV, 01=DIVU, 10=REM, 11=REMU; sampled with div_start
div_in1  input  XLEN  dividend (rs1); sampled with div_start
div_in2  input  XLEN  divisor (rs2); sampled with div_start
div_flush  input  1  abort in-flight operation (pipeline flush)
div_busy  output  1  high while in CALC or DONE
div_done  output  1  one-cycle pulse; div_out valid in this cycle
div_out  output  XLEN  quotient or remainder per div_op; held until the next accepted start

Behaviour:
- Reset (rst_n low at a clock edge):
  - State goes to IDLE; div_busy=0, div_done=0, div_out=0; internal counter, quotient and remainder registers cleared.
  - Reset overrides div_start and div_flush in the same cycle.
  - Reset asserted mid-CALC aborts the operation with no div_done pulse.
- States: IDLE, CALC, DONE.
- IDLE:
  - div_start=1 latches the op and operands; div_start is ignored in every other state.
  - Signed ops (DIV/REM) take magnitudes of the operands. Record the quotient sign (sign1 XOR sign2) and the remainder sign (sign1).
  - If div_in2==0: result is quotient=all ones (-1), remainder=div_in1. Go directly to DONE.
  - If signed op and div_in1=0x8000_0000 (MSB only) and div_in2=all ones: result is quotient=0x8000_0000, remainder=0. Go directly to DONE.
  - Otherwise: remainder register=0, quotient register=|dividend|, counter=0, go to CALC.
- CALC (one iteration per cycle):
  - Shift {rem,quo} left by 1, giving a trial value.
  - If trial rem >= |divisor| (unsigned, XLEN+1-bit compare): rem -= |divisor| and the quotient LSB is 1. Otherwise rem is kept and the quotient LSB is 0.
  - Counter increments. After the XLEN-th iteration (counter==XLEN-1 at the edge), go to DONE.
- DONE (exactly one cycle):
  - div_done=1 and div_out is valid in this cycle.
  - Signed ops negate the quotient if its recorded sign is negative, and negate the remainder if the dividend was negative.
  - div_out is registered on entry to DONE. Next state is IDLE.
  - div_start in the DONE cycle is ignored; the requester waits for div_busy=0.
- Latency (start accepted at edge E):
  - Normal ops: div_done high in the cycle after edge E+XLEN+1, i.e. 34 cycles for XLEN=32.
  - Special cases: div_done high in the cycle after edge E+1.
  - Throughput: one op per XLEN+2 cycles; back-to-back start is allowed in the cycle after DONE.
- div_flush:
  - In CALC or DONE: next state IDLE, no div_done pulse (div_done is forced 0 in that cycle if already in DONE), div_out unchanged.
  - In IDLE: suppresses a simultaneous div_start.
- div_out: holds its last value through IDLE and CALC; changes only on entry to DONE or on reset.
- All arithmetic is modulo 2^XLEN. Negation is two's complement.
- Magnitude of 0x8000_0000 is 0x8000_0000, treated as unsigned.

Test Plan:
- DIVU 100/7, start in IDLE -> busy for 33 cycles; div_done on cycle 34 with div_out=14. Repeat as REMU -> div_out=2.
- DIV 0xFFFF_FF9C (-100)/7 -> div_out=0xFFFF_FFF2 (-14). REM -100/7 -> 0xFFFF_FFFE (-2). REM 100/-7 -> 2.
- Divide by zero: DIV 123/0 -> div_done 2 cycles after start, div_out=0xFFFF_FFFF. REMU 123/0 -> div_out=123.
- Overflow: DIV 0x8000_0000/0xFFFF_FFFF -> div_out=0x8000_0000 with fast latency. REM same operands -> 0.
- Flush at iteration 10 of DIVU 0xFFFF_FFFF/3 -> no div_done, div_busy=0 next cycle, div_out keeps prior value. A new start then yields 0x5555_5555.
- Start pulsed during CALC with other operands -> ignored; original result delivered. rst_n low mid-CALC -> all outputs 0 next cycle, no done pulse.
